// File: rtl/relogio_pkg.sv
// relogio_pkg: BCD digit type and seven-segment codes (a..g on bits 6..0, active-high)
package relogio_pkg;
    typedef logic [3:0] bcd_t;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to seven-segment decoder, non-decimal codes blank
module bcd_to_7seg
    import relogio_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);
    // table lookup; anything above 9 shows nothing
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/relogio.sv
// relogio: 24-hour HH:MM:SS clock with 1 Hz divider and six seven-segment outputs
module relogio
    import relogio_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd
);
    localparam int DW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [DW-1:0] r_div;
    bcd_t r_s_lsd, r_s_msd, r_m_lsd, r_m_msd, r_h_lsd, r_h_msd;
    logic w_s59, w_m59, w_h23;
    logic enable1hz, incrementa_minuto, incrementa_hora;

    assign w_s59 = (r_s_msd == 4'd5) && (r_s_lsd == 4'd9);
    assign w_m59 = (r_m_msd == 4'd5) && (r_m_lsd == 4'd9);
    assign w_h23 = (r_h_msd == 4'd2) && (r_h_lsd == 4'd3);

    // strobes are gated by reset so nothing pulses while the clock is being cleared
    assign enable1hz         = !reset && (r_div == DW'(TICKS_PER_SEC - 1));
    assign incrementa_minuto = enable1hz && w_s59;
    assign incrementa_hora   = incrementa_minuto && w_m59;

    // divider and all six digits advance together so 23:59:59 rolls over in one edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div   <= '0;
            r_s_lsd <= '0;
            r_s_msd <= '0;
            r_m_lsd <= '0;
            r_m_msd <= '0;
            r_h_lsd <= '0;
            r_h_msd <= '0;
        end else begin
            r_div <= enable1hz ? '0 : r_div + 1'b1;
            if (enable1hz)
                r_s_lsd <= (r_s_lsd == 4'd9) ? '0 : r_s_lsd + 1'b1;
            if (enable1hz && r_s_lsd == 4'd9)
                r_s_msd <= (r_s_msd == 4'd5) ? '0 : r_s_msd + 1'b1;
            if (incrementa_minuto)
                r_m_lsd <= (r_m_lsd == 4'd9) ? '0 : r_m_lsd + 1'b1;
            if (incrementa_minuto && r_m_lsd == 4'd9)
                r_m_msd <= (r_m_msd == 4'd5) ? '0 : r_m_msd + 1'b1;
            if (incrementa_hora) begin
                r_h_lsd <= (w_h23 || r_h_lsd == 4'd9) ? '0 : r_h_lsd + 1'b1;
                r_h_msd <= w_h23 ? '0 : (r_h_lsd == 4'd9) ? r_h_msd + 1'b1 : r_h_msd;
            end
        end
    end

    bcd_to_7seg u_s_lsd (.i_bcd(r_s_lsd), .o_seg(s_lsd));
    bcd_to_7seg u_s_msd (.i_bcd(r_s_msd), .o_seg(s_msd));
    bcd_to_7seg u_m_lsd (.i_bcd(r_m_lsd), .o_seg(m_lsd));
    bcd_to_7seg u_m_msd (.i_bcd(r_m_msd), .o_seg(m_msd));
    bcd_to_7seg u_h_lsd (.i_bcd(r_h_lsd), .o_seg(h_lsd));
    bcd_to_7seg u_h_msd (.i_bcd(r_h_msd), .o_seg(h_msd));
endmodule

// File: tb/tb_relogio.sv
// tb_relogio: directed self-checking bench for relogio with a 4-cycle second
module tb_relogio;
    localparam int T = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd;
    int tests = 0;
    int fails = 0;

    relogio #(.TICKS_PER_SEC(T)) dut (
        .clock(clock),
        .reset(reset),
        .s_lsd(s_lsd),
        .s_msd(s_msd),
        .m_lsd(m_lsd),
        .m_msd(m_msd),
        .h_lsd(h_lsd),
        .h_msd(h_msd)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".h_msd"}, h_msd, seg(h / 10));
        check({tag, ".h_lsd"}, h_lsd, seg(h % 10));
        check({tag, ".m_msd"}, m_msd, seg(m / 10));
        check({tag, ".m_lsd"}, m_lsd, seg(m % 10));
        check({tag, ".s_msd"}, s_msd, seg(s / 10));
        check({tag, ".s_lsd"}, s_lsd, seg(s % 10));
    endtask

    task automatic check_strobes(input string tag, input logic e, input logic mi, input logic ho);
        check({tag, ".enable1hz"}, {6'b0, dut.enable1hz}, {6'b0, e});
        check({tag, ".incrementa_minuto"}, {6'b0, dut.incrementa_minuto}, {6'b0, mi});
        check({tag, ".incrementa_hora"}, {6'b0, dut.incrementa_hora}, {6'b0, ho});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    // load a time with the divider at 0; the tick then lands on the 4th edge
    task automatic preload(input int h, input int m, input int s);
        @(negedge clock);
        force dut.r_h_msd = 4'(h / 10);
        force dut.r_h_lsd = 4'(h % 10);
        force dut.r_m_msd = 4'(m / 10);
        force dut.r_m_lsd = 4'(m % 10);
        force dut.r_s_msd = 4'(s / 10);
        force dut.r_s_lsd = 4'(s % 10);
        force dut.r_div = '0;
        #1;
        release dut.r_h_msd;
        release dut.r_h_lsd;
        release dut.r_m_msd;
        release dut.r_m_lsd;
        release dut.r_s_msd;
        release dut.r_s_lsd;
        release dut.r_div;
    endtask

    task automatic tick_check(input string tag, input int h0, input int m0, input int s0,
                              input logic mi, input logic ho,
                              input int h1, input int m1, input int s1);
        preload(h0, m0, s0);
        check_time({tag, ".pre"}, h0, m0, s0);
        step(3);
        check_strobes({tag, ".edge"}, 1'b1, mi, ho);
        check_time({tag, ".hold"}, h0, m0, s0);
        step(1);
        check_time({tag, ".post"}, h1, m1, s1);
        check_strobes({tag, ".after"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int sec;
        step(3);
        check_time("reset", 0, 0, 0);
        check_strobes("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            sec = k / T;
            check($sformatf("tick%0d.enable1hz", k), {6'b0, dut.enable1hz}, {6'b0, (k % T) == T - 1});
            check($sformatf("tick%0d.s_lsd", k), s_lsd, seg(sec % 10));
            check($sformatf("tick%0d.s_msd", k), s_msd, seg(sec / 10));
        end
        check("tick.m_lsd", m_lsd, seg(0));
        tick_check("s2m", 0, 0, 59, 1'b1, 1'b0, 0, 1, 0);
        tick_check("s_mid", 0, 7, 29, 1'b0, 1'b0, 0, 7, 30);
        tick_check("m2h", 0, 59, 59, 1'b1, 1'b1, 1, 0, 0);
        tick_check("h09", 9, 59, 59, 1'b1, 1'b1, 10, 0, 0);
        tick_check("h19", 19, 59, 59, 1'b1, 1'b1, 20, 0, 0);
        tick_check("day", 23, 59, 59, 1'b1, 1'b1, 0, 0, 0);
        preload(12, 34, 56);
        step(3);
        check_strobes("midrst.edge", 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_strobes("midrst.asserted", 1'b0, 1'b0, 1'b0);
        step(1);
        check_time("midrst", 0, 0, 0);
        reset = 1'b0;
        step(3);
        check_time("midrst.resume", 0, 0, 0);
        check_strobes("midrst.resume", 1'b1, 1'b0, 1'b0);
        step(1);
        check_time("midrst.first", 0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
